// File: rtl/data_ram_responder.sv
// Data-RAM slave for the CPU MEM stage.
// Loads are combinational. Stores are posted into a one-entry write buffer
// and written into the array on the following edge.
// Byte-lane forwarding from the buffer hides the posting delay from the CPU.
module data_ram_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        wr_pending_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Storage array. It has no reset and is undefined at power-up.
  logic [31:0] mem_r [DEPTH];

  // One-entry posted-write buffer.
  logic                  pv_r;
  logic [DEPTH_LOG2-1:0] pidx_r;
  logic [3:0]            psel_r;
  logic [31:0]           pdata_r;

  // Decode of the current access.
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  cap_s;
  logic                  hit_s;
  logic [31:0]           rd_word_s;
  logic                  unused_addr_s;

  // Expand a 4-bit lane enable into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        m[8*i +: 8] = 8'hFF;
      end else begin
        m[8*i +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  // Per-lane merge. Lanes enabled in the buffer take the buffered byte.
  // All other lanes take the array byte.
  function automatic logic [31:0] fwd_merge(input logic [31:0] arr_word,
                                            input logic [31:0] buf_word,
                                            input logic [3:0]  lanes);
    logic [31:0] m;
    m = lane_mask(lanes);
    return (buf_word & m) | (arr_word & ~m);
  endfunction

  // The word index ignores addr[1:0] and every bit above the array depth.
  // The ignored bits are gathered here so that none of them is left
  // dangling.
  assign idx_s         = addr[DEPTH_LOG2+1:2];
  assign unused_addr_s = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  // A store that enables no lanes is a no-op and does not load the buffer.
  assign cap_s = ce & we & (sel != 4'b0000);

  assign rd_word_s = mem_r[idx_s];
  assign hit_s     = pv_r & (pidx_r == idx_s);

  // Write buffer: capture new stores, drop the entry once it has committed,
  // and discard any uncommitted entry on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r    <= 1'b0;
      pidx_r  <= {DEPTH_LOG2{1'b0}};
      psel_r  <= 4'b0000;
      pdata_r <= 32'h0000_0000;
    end else if (cap_s) begin
      pv_r    <= 1'b1;
      pidx_r  <= idx_s;
      psel_r  <= sel;
      pdata_r <= data_i;
    end else begin
      pv_r    <= 1'b0;
    end
  end

  // Commit the buffered store into the array. The commit is byte-lane
  // masked and is suppressed under reset, so a pending store is discarded.
  // This is the older store when a capture happens on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && pv_r) begin
      for (int i = 0; i < 4; i++) begin
        if (psel_r[i]) begin
          mem_r[pidx_r][8*i +: 8] <= pdata_r[8*i +: 8];
        end
      end
    end
  end

  // Combinational load path with lane forwarding from the write buffer.
  // The output is zero during reset, on stores, and when ce is low.
  always_comb begin
    data_o = 32'h0000_0000;
    if (rst) begin
      data_o = 32'h0000_0000;
    end else if (ce && !we) begin
      if (hit_s) begin
        data_o = fwd_merge(rd_word_s, pdata_r, psel_r);
      end else begin
        data_o = rd_word_s;
      end
    end else begin
      data_o = 32'h0000_0000;
    end
  end

  assign wr_pending_o = pv_r;

endmodule
